pipe_datapath: RTL and testbench
================================

PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
- REQ-001: Parameter WIDTH, default 32, datapath and register width in bits (>= 8).
- REQ-002: Parameter NREG, default 4, number of registers (power of two, >= 2); AW = clog2(NREG).
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst  input  1  reset, asynchronous, active-low.
- REQ-005: in_valid  input  1  request present.
- REQ-006: in_ready  output  1  block can accept a request this cycle.
- REQ-007: alu_ctrl  input  3  operation select.
- REQ-008: addr1, addr2, addr3  input  AW each  source A, source B, destination register.
- REQ-009: wr  input  1  write result to addr3 at commit.
- REQ-010: use_imm  input  1  select imm instead of register[addr2] as operand B.
- REQ-011: imm  input  WIDTH  immediate operand.
- REQ-012: out_valid  output  1  result/flags valid.
- REQ-013: out_ready  input  1  consumer accepts the result.
- REQ-014: result  output  WIDTH  registered ALU result.
- REQ-015: zero, overflow  output  1 each  registered flags.

Function
- REQ-016: Ops: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1 or 0), 110 SLL (A << B[clog2(WIDTH)-1:0]), 111 SRL (logical, same amount field).
- REQ-017: Arithmetic modulo 2^WIDTH; overflow = signed overflow for ADD/SUB only, 0 for all other ops.
- REQ-018: zero = 1 iff the committed result equals 0, for every op.
- REQ-019: Two stages: EX register (operands, op, wr, addr3, valid) and OUT register (result, flags, out_valid).
- REQ-020: Accept on rising edge when in_valid && in_ready; operands captured into EX on that edge.
- REQ-021: EX commits to OUT when EX valid and OUT can advance. On that edge: OUT loads ALU result and flags, and register[addr3] is written if wr. Result latency = 2 edges from accept; issue rate 1 per cycle with no stall.
- REQ-022: OUT can advance when !out_valid || out_ready; in_ready = !EX_valid || OUT can advance.
- REQ-023: Stall: OUT and EX hold every field unchanged and no register write occurs.
- REQ-024: out_valid clears on out_ready when no EX commit occurs on the same edge.
- REQ-025: Forwarding: if EX is valid with wr=1 and EX.addr3 matches addr1 (or addr2 with use_imm=0), the operand read returns the EX ALU result, not the register file.
- REQ-026: Without a forwarding match, operand reads return current register-file contents, including a write performed on the same edge.
- REQ-027: All NREG registers are writable; no hardwired-zero register.
- REQ-028: addr3 equal to addr1/addr2 in one request: operands are old values, write lands at commit.
- REQ-029: wr=0 requests still produce result/flags and out_valid with no register change.

Reset
- REQ-030: When rst is asserted, asynchronously: all registers, EX, result, zero and overflow go to 0; out_valid goes to 0.
- REQ-031: in_ready is 1 from reset release.
- REQ-032: Reset mid-operation discards in-flight requests with no register write.
- REQ-033: First accept is allowed on the first rising edge after rst deasserts.

Verification (WIDTH=32, NREG=4)
- REQ-034: Test 1 (reset): assert rst mid-stream -> out_valid=0, result=0, all registers 0 immediately, without waiting for a clock edge.
- REQ-035: Test 2 (immediate load, then subtract): R3 <- R0+imm 1, R1 <- R0+imm 5, then SUB R2 <- R1-R3. Issue back-to-back with out_ready=1. Required: third result 00000004, R2=4, zero=0.
- REQ-036: Test 3 (forwarding): ADD R1 <- R0+imm 7, immediately followed by ADD R2 <- R1+R1 -> result 0000000E.
- REQ-037: Test 4 (overflow/zero): ADD 7FFFFFFF+1 -> 80000000, overflow=1. SUB 5-5 -> 0, zero=1, overflow=0. SUB 80000000-1 -> 7FFFFFFF, overflow=1.
- REQ-038: Test 5 (backpressure): out_ready=0 for 3 cycles with two requests issued. Required: in_ready=0 after the second is accepted, result held stable, no lost or duplicated results, and register writes occur in order.
- REQ-039: Test 6 (shift/SLT): SLL 1 by 31 -> 80000000. SRL 80000000 by 31 -> 1. SLT FFFFFFFF,1 -> 1.

Source files
------------

// File: rtl/pipe_datapath_if.sv
// Request/response bundle for pipe_datapath: issue-side handshake with operand
// selects, and the registered result handshake with flags.
interface pipe_datapath_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 4
);
  localparam int unsigned AW = $clog2(NREG);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_ctrl;
  logic [AW-1:0]    addr1;
  logic [AW-1:0]    addr2;
  logic [AW-1:0]    addr3;
  logic             wr;
  logic             use_imm;
  logic [WIDTH-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, alu_ctrl, addr1, addr2, addr3, wr, use_imm, imm, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, alu_ctrl, addr1, addr2, addr3, wr, use_imm, imm, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/pipe_datapath.sv
// Two-stage register-file ALU pipeline: EX holds captured operands, OUT holds the
// registered result and flags; the register file is written when EX commits to OUT.
module pipe_datapath #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREG  = 4
) (
  input  logic            clk,
  input  logic            rst,
  pipe_datapath_if.slave  bus
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned SW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpSlt = 3'b101,
    OpSll = 3'b110,
    OpSrl = 3'b111
  } op_e;

  logic [WIDTH-1:0] rf_q [NREG];

  logic             ex_valid_q, ex_valid_d;
  op_e              ex_op_q, ex_op_d;
  logic [WIDTH-1:0] ex_a_q, ex_a_d;
  logic [WIDTH-1:0] ex_b_q, ex_b_d;
  logic             ex_wr_q, ex_wr_d;
  logic [AW-1:0]    ex_addr3_q, ex_addr3_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             out_adv;
  logic             commit;
  logic             in_ready;
  logic             accept;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    shamt;

  logic             fwd_a;
  logic             fwd_b;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  // Handshake: OUT drains or is empty; EX moves whenever OUT can take it.
  always_comb begin
    out_adv  = !out_valid_q || bus.out_ready;
    commit   = ex_valid_q && out_adv;
    in_ready = !ex_valid_q || out_adv;
    accept   = bus.in_valid && in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;

  // ALU on the EX-stage operands.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = ex_a_q + ex_b_q;
    diff    = ex_a_q - ex_b_q;
    shamt   = ex_b_q[SW-1:0];
    unique case (ex_op_q)
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (ex_a_q[WIDTH-1] == ex_b_q[WIDTH-1]) && (sum[WIDTH-1] != ex_a_q[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (ex_a_q[WIDTH-1] != ex_b_q[WIDTH-1]) && (diff[WIDTH-1] != ex_a_q[WIDTH-1]);
      end
      OpAnd: alu_res = ex_a_q & ex_b_q;
      OpOr:  alu_res = ex_a_q | ex_b_q;
      OpXor: alu_res = ex_a_q ^ ex_b_q;
      OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(ex_a_q) < $signed(ex_b_q))};
      OpSll: alu_res = ex_a_q << shamt;
      OpSrl: alu_res = ex_a_q >> shamt;
      default: alu_res = '0;
    endcase
  end

  // Operand read. The only write that can land on the accept edge is the EX
  // commit, so forwarding the EX result covers the same-edge write case.
  always_comb begin
    fwd_a = ex_valid_q && ex_wr_q && (ex_addr3_q == bus.addr1);
    fwd_b = ex_valid_q && ex_wr_q && !bus.use_imm && (ex_addr3_q == bus.addr2);
    opa   = fwd_a ? alu_res : rf_q[bus.addr1];
    if (bus.use_imm) begin
      opb = bus.imm;
    end else if (fwd_b) begin
      opb = alu_res;
    end else begin
      opb = rf_q[bus.addr2];
    end
  end

  // EX stage next state.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_wr_d    = ex_wr_q;
    ex_addr3_d = ex_addr3_q;
    if (accept) begin
      ex_valid_d = 1'b1;
      ex_op_d    = op_e'(bus.alu_ctrl);
      ex_a_d     = opa;
      ex_b_d     = opb;
      ex_wr_d    = bus.wr;
      ex_addr3_d = bus.addr3;
    end else if (commit) begin
      ex_valid_d = 1'b0;
    end
  end

  // OUT stage next state; result and flags only change on a commit.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    if (commit) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      ovf_d       = alu_ovf;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_op_q     <= OpAdd;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_wr_q     <= 1'b0;
      ex_addr3_q  <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_wr_q     <= ex_wr_d;
      ex_addr3_q  <= ex_addr3_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (commit && ex_wr_q && (ex_addr3_q == AW'(i))) begin
          rf_q[i] <= alu_res;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_datapath.sv
// Bench for pipe_datapath: directed vector table, backpressure and reset sequences,
// then randomized traffic scored against a sequential architectural model.
module tb_pipe_datapath;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREG  = 4;
  localparam longint MaxS = 2147483647;
  localparam longint MinS = -MaxS - 1;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  a1, a2, a3;
    logic        wr, ui;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] res;
    logic        z, o;
  } exp_t;

  typedef struct {
    req_t r;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_datapath_if #(.WIDTH(WIDTH), .NREG(NREG)) bus ();
  pipe_datapath #(.WIDTH(WIDTH), .NREG(NREG)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_pass = 0;
  int          n_total = 0;
  exp_t        expq[$];
  logic [31:0] mreg[NREG];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_res;
  vec_t        tbl[19];
  req_t        idle;
  exp_t        nox;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, want);
  endtask

  function automatic req_t mk(input logic [2:0] op, input logic [1:0] a1, input logic [1:0] a2,
                              input logic [1:0] a3, input logic wr, input logic ui,
                              input logic [31:0] imm);
    req_t r;
    r.op = op; r.a1 = a1; r.a2 = a2; r.a3 = a3; r.wr = wr; r.ui = ui; r.imm = imm;
    return r;
  endfunction

  function automatic exp_t ex(input logic [31:0] res, input logic z, input logic o);
    exp_t e;
    e.res = res; e.z = z; e.o = o;
    return e;
  endfunction

  // Architectural reference: plain arithmetic, overflow by range check on wide sums.
  function automatic exp_t alu_model(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    exp_t   e;
    longint s;
    e.o = 1'b0;
    case (op)
      3'd0: begin
        e.res = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.o = (s > MaxS) || (s < MinS);
      end
      3'd1: begin
        e.res = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.o = (s > MaxS) || (s < MinS);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: e.res = a << b[4:0];
      default: e.res = a >> b[4:0];
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Requests execute in order, so each sees every earlier request's write.
  task automatic model_issue(input req_t r, output exp_t e);
    logic [31:0] b;
    b = r.ui ? r.imm : mreg[r.a2];
    e = alu_model(r.op, mreg[r.a1], b);
    if (r.wr) mreg[r.a3] = e.res;
  endtask

  task automatic step(input logic v, input req_t r, input logic ordy, input logic use_tbl,
                      input exp_t te, input string tag, output logic acc);
    exp_t e;
    exp_t m;
    @(negedge clk);
    bus.in_valid  = v;
    bus.alu_ctrl  = r.op;
    bus.addr1     = r.a1;
    bus.addr2     = r.a2;
    bus.addr3     = r.a3;
    bus.wr        = r.wr;
    bus.use_imm   = r.ui;
    bus.imm       = r.imm;
    bus.out_ready = ordy;
    #1;
    if (hold_pend) begin
      check({tag, " held result"}, bus.result, hold_res);
      check({tag, " held valid"}, {31'd0, bus.out_valid}, 32'd1);
    end
    hold_pend = bus.out_valid && !ordy;
    hold_res  = bus.result;
    if (bus.out_valid && ordy) begin
      if (expq.size() == 0) begin
        check({tag, " spurious out_valid"}, {31'd0, bus.out_valid}, 32'd0);
      end else begin
        e = expq.pop_front();
        check({tag, " result"}, bus.result, e.res);
        check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, e.z});
        check({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, e.o});
      end
    end
    acc = v && bus.in_ready;
    if (acc) begin
      model_issue(r, m);
      expq.push_back(use_tbl ? te : m);
    end
    @(posedge clk);
  endtask

  task automatic drain(input string tag);
    logic acc;
    for (int i = 0; i < 40 && expq.size() != 0; i++) step(1'b0, idle, 1'b1, 1'b0, nox, tag, acc);
    check({tag, " drain leftover"}, expq.size(), 0);
  endtask

  task automatic run_tbl(input int lo, input int hi);
    logic acc;
    for (int i = lo; i <= hi; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 5 && !acc; t++)
        step(1'b1, tbl[i].r, 1'b1, 1'b1, tbl[i].e, $sformatf("vec%0d", i), acc);
      check($sformatf("vec%0d accepted", i), {31'd0, acc}, 32'd1);
    end
    drain("tbl");
  endtask

  task automatic check_regs(input string tag, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3);
    check({tag, " R0"}, dut.rf_q[0], r0);
    check({tag, " R1"}, dut.rf_q[1], r1);
    check({tag, " R2"}, dut.rf_q[2], r2);
    check({tag, " R3"}, dut.rf_q[3], r3);
  endtask

  initial begin
    logic  acc;
    req_t  r;
    idle = mk(3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0);
    nox  = ex(32'd0, 1'b0, 1'b0);
    for (int i = 0; i < int'(NREG); i++) mreg[i] = 32'd0;
    bus.in_valid = 1'b0; bus.alu_ctrl = 3'd0; bus.addr1 = 2'd0; bus.addr2 = 2'd0;
    bus.addr3 = 2'd0; bus.wr = 1'b0; bus.use_imm = 1'b0; bus.imm = 32'd0;
    bus.out_ready = 1'b1;

    // op: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLT 6 SLL 7 SRL
    tbl[0]  = '{mk(3'd0, 2'd0, 2'd0, 2'd3, 1, 1, 32'd1), ex(32'd1, 0, 0)};
    tbl[1]  = '{mk(3'd0, 2'd0, 2'd0, 2'd1, 1, 1, 32'd5), ex(32'd5, 0, 0)};
    tbl[2]  = '{mk(3'd1, 2'd1, 2'd3, 2'd2, 1, 0, 32'd0), ex(32'd4, 0, 0)};
    tbl[3]  = '{mk(3'd0, 2'd0, 2'd0, 2'd1, 1, 1, 32'd7), ex(32'd7, 0, 0)};
    tbl[4]  = '{mk(3'd0, 2'd1, 2'd1, 2'd2, 1, 0, 32'd0), ex(32'h0000000E, 0, 0)};
    tbl[5]  = '{mk(3'd0, 2'd0, 2'd0, 2'd1, 1, 1, 32'h7FFFFFFF), ex(32'h7FFFFFFF, 0, 0)};
    tbl[6]  = '{mk(3'd0, 2'd1, 2'd0, 2'd2, 1, 1, 32'd1), ex(32'h80000000, 0, 1)};
    tbl[7]  = '{mk(3'd0, 2'd0, 2'd0, 2'd3, 1, 1, 32'd5), ex(32'd5, 0, 0)};
    tbl[8]  = '{mk(3'd1, 2'd3, 2'd0, 2'd0, 1, 1, 32'd5), ex(32'd0, 1, 0)};
    tbl[9]  = '{mk(3'd1, 2'd2, 2'd0, 2'd1, 1, 1, 32'd1), ex(32'h7FFFFFFF, 0, 1)};
    tbl[10] = '{mk(3'd0, 2'd0, 2'd0, 2'd1, 1, 1, 32'd1), ex(32'd1, 0, 0)};
    tbl[11] = '{mk(3'd6, 2'd1, 2'd0, 2'd2, 1, 1, 32'd31), ex(32'h80000000, 0, 0)};
    tbl[12] = '{mk(3'd7, 2'd2, 2'd0, 2'd3, 1, 1, 32'd31), ex(32'd1, 0, 0)};
    tbl[13] = '{mk(3'd0, 2'd0, 2'd0, 2'd1, 1, 1, 32'hFFFFFFFF), ex(32'hFFFFFFFF, 0, 0)};
    tbl[14] = '{mk(3'd5, 2'd1, 2'd0, 2'd0, 0, 1, 32'd1), ex(32'd1, 0, 0)};
    tbl[15] = '{mk(3'd4, 2'd1, 2'd0, 2'd3, 1, 1, 32'h0F0F0F0F), ex(32'hF0F0F0F0, 0, 0)};
    tbl[16] = '{mk(3'd5, 2'd0, 2'd1, 2'd0, 0, 0, 32'd0), ex(32'd0, 1, 0)};
    tbl[17] = '{mk(3'd2, 2'd3, 2'd0, 2'd0, 0, 1, 32'h00FF00FF), ex(32'h00F000F0, 0, 0)};
    tbl[18] = '{mk(3'd3, 2'd3, 2'd0, 2'd0, 0, 1, 32'd1), ex(32'hF0F0F0F1, 0, 0)};

    // Asynchronous reset: visible before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;

    run_tbl(0, 2);
    check_regs("imm/sub", 32'd0, 32'd5, 32'd4, 32'd1);
    run_tbl(3, 18);
    check_regs("tbl end", 32'd0, 32'hFFFFFFFF, 32'h80000000, 32'hF0F0F0F0);

    // Backpressure: two dependent writes to R1 while the consumer stalls.
    step(1'b1, mk(3'd0, 2'd0, 2'd0, 2'd1, 1, 1, 32'd10), 1'b0, 1'b1, ex(32'd10, 0, 0), "bp1", acc);
    check("bp first accepted", {31'd0, acc}, 32'd1);
    step(1'b1, mk(3'd0, 2'd1, 2'd0, 2'd1, 1, 1, 32'd10), 1'b0, 1'b1, ex(32'd20, 0, 0), "bp2", acc);
    check("bp second accepted", {31'd0, acc}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp in_ready c%0d", i), {31'd0, bus.in_ready}, 32'd0);
      check($sformatf("bp result c%0d", i), bus.result, 32'd10);
      check($sformatf("bp R1 c%0d", i), dut.rf_q[1], 32'd10);
      step(1'b0, idle, 1'b0, 1'b0, nox, "bp stall", acc);
    end
    drain("bp");
    check("bp R1 final", dut.rf_q[1], 32'd20);

    // Randomized traffic against the architectural model.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] specials[5];
      specials[0] = 32'd0; specials[1] = 32'd1; specials[2] = 32'h7FFFFFFF;
      specials[3] = 32'h80000000; specials[4] = 32'hFFFFFFFF;
      r = mk(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 4)] : $urandom);
      step($urandom_range(0, 9) < 7, r, $urandom_range(0, 9) < 7, 1'b0, nox, "rnd", acc);
    end
    drain("rnd");
    check_regs("rnd end", mreg[0], mreg[1], mreg[2], mreg[3]);

    // Reset mid-stream with requests in flight and the consumer stalled.
    step(1'b1, mk(3'd0, 2'd0, 2'd0, 2'd2, 1, 1, 32'h55), 1'b0, 1'b0, nox, "mid", acc);
    step(1'b1, mk(3'd0, 2'd0, 2'd0, 2'd3, 1, 1, 32'h66), 1'b0, 1'b0, nox, "mid", acc);
    step(1'b1, mk(3'd0, 2'd0, 2'd0, 2'd1, 1, 1, 32'h77), 1'b0, 1'b0, nox, "mid", acc);
    #2 rst = 1'b0;
    #1;
    check("mid reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid reset result", bus.result, 32'd0);
    check("mid reset zero", {31'd0, bus.zero}, 32'd0);
    check("mid reset overflow", {31'd0, bus.overflow}, 32'd0);
    check_regs("mid reset", 32'd0, 32'd0, 32'd0, 32'd0);
    expq.delete();
    hold_pend = 1'b0;
    for (int i = 0; i < int'(NREG); i++) mreg[i] = 32'd0;
    @(posedge clk);
    #2 rst = 1'b1;

    step(1'b1, mk(3'd0, 2'd0, 2'd0, 2'd2, 1, 1, 32'd9), 1'b1, 1'b1, ex(32'd9, 0, 0), "post", acc);
    check("post first accept", {31'd0, acc}, 32'd1);
    check_regs("post no stale write", 32'd0, 32'd0, 32'd0, 32'd0);
    drain("post");
    check_regs("post", 32'd0, 32'd0, 32'd9, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
